cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Sequences and shares the core's single-port synchronous data memory between two requesters: instruction fetch (IF) and the MEM-stage memory unit (DM).
- Performs sub-word lane extraction and sign/zero extension for loads.
- Performs read-modify-write (RMW) merging for SB/SH, so the memory unit only issues byte-addressed requests and never masks data itself.
- Sits between the IF/MEM stages and the memory port of the core.

Parameters:
STARVE_LIMIT, 4, consecutive DM grants allowed while IF is pending before IF is forced a grant; legal range 1..15
CNT_W, $clog2(STARVE_LIMIT+1), width of the starvation counter (derived; do not override)

Ports:
i_clk  in  1  core clock
i_reset_n  in  1  asynchronous active-low reset
i_if_req  in  1  fetch request; held with i_if_addr stable until o_if_gnt
i_if_addr  in  32  fetch byte address; bits [1:0] ignored
o_if_gnt  out  1  one-cycle pulse: fetch request accepted
o_if_rvalid  out  1  one-cycle pulse: o_if_rdata valid
o_if_rdata  out  32  fetched instruction word
i_dm_req  in  1  data request; held with all i_dm_* stable until o_dm_gnt
i_dm_we  in  1  1 = store, 0 = load
i_dm_size  in  2  00 byte, 01 half, 10 word, 11 reserved
i_dm_unsigned  in  1  load zero-extend (LBU/LHU)
i_dm_addr  in  32  data byte address
i_dm_wdata  in  32  store data, right-justified
o_dm_gnt  out  1  one-cycle pulse: data request accepted
o_dm_rvalid  out  1  one-cycle pulse: load data valid
o_dm_rdata  out  32  extended load data
o_dm_done  out  1  one-cycle pulse: store written to memory
o_dm_err  out  1  one-cycle pulse, coincident with o_dm_gnt: misaligned or reserved-size request
o_mem_addr  out  32  word address {addr[31:2],2'b00}
o_mem_we  out  1  memory write enable
o_mem_wdata  out  32  memory write word
i_mem_rdata  in  32  read word, valid the cycle after o_mem_addr is presented with o_mem_we=0

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; starvation counter=0; latched request cleared.
  - All outputs 0.
  - An in-flight access is dropped. No o_mem_we pulse may occur during or after reset for a dropped request.
- Default output values: o_mem_addr=0, o_mem_we=0, o_mem_wdata=0 when not in READ/WRITE.
- FSM states: IDLE, READ, RESP, WRITE.
  - IDLE: arbitrate. On a winner, pulse the requester's gnt combinationally and latch owner/addr/we/size/unsigned/wdata. Next state:
    - load or fetch -> READ
    - word store -> WRITE
    - byte/half store -> READ
  - READ: drive o_mem_addr from the latch, o_mem_we=0 -> RESP.
  - RESP: i_mem_rdata is valid.
    - Fetch: o_if_rvalid=1, o_if_rdata=i_mem_rdata -> IDLE.
    - Load: o_dm_rvalid=1, o_dm_rdata=extended lane -> IDLE.
    - Sub-word store: register the merged word -> WRITE.
  - WRITE: o_mem_we=1, o_mem_wdata=latched word or merged word; o_dm_done=1 -> IDLE.
- Latency (gnt at cycle N):
  - load/fetch: rvalid at N+2
  - SW: done at N+1
  - SB/SH: done at N+3
  - Next grant is possible in the cycle after a transaction returns to IDLE.
- Arbitration: DM has priority over IF, unless IF is pending and counter==STARVE_LIMIT, in which case IF wins.
  - Counter increments on each DM grant while i_if_req=1.
  - Counter clears on an IF grant or whenever i_if_req=0.
  - Counter saturates at STARVE_LIMIT.
- Lanes: byte lane = addr[1:0]; half lane = addr[1].
  - Load: shift the selected lane to [7:0] or [15:0], then sign-extend, or zero-extend if i_dm_unsigned.
  - Merge: replace only the selected lane with i_dm_wdata[7:0] or [15:0]; other bytes come from i_mem_rdata.
- Errors: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Response in the IDLE grant cycle: o_dm_gnt=1 and o_dm_err=1; stay in IDLE; no memory access.
  - An error grant counts as a DM grant for the starvation counter.
- Requests:
  - Dropping req before gnt is legal and produces no grant.
  - A req asserted while not IDLE waits.
  - Simultaneous IF and DM requests in IDLE follow the arbitration rule above.

Decomposition:
- Package cpu_mem_arb_pkg:
  - state enum mem_arb_state_t {IDLE, READ, RESP, WRITE}
  - owner enum {OWN_IF, OWN_DM}
  - size constants SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10
- Sub-module cpu_mem_lane_unit (combinational): load extraction/extension, store merge, and the misalign check. It is reused by the arbiter and by its verification model.

Test Plan:
- Reset mid-operation: assert i_reset_n=0 during RESP of SB 0x101 -> no o_mem_we pulse; all outputs 0; next request is granted normally.
- LW: addr 0x100, mem=0xDEADBEEF -> gnt at N, o_mem_addr=0x100 at N+1, o_dm_rvalid with 0xDEADBEEF at N+2.
- Sub-word loads, mem[0x100]=0x80112233:
  - LB 0x103 -> 0xFFFFFF80
  - LBU 0x103 -> 0x00000080
  - LH 0x102 -> 0xFFFF8011
  - LHU 0x100 -> 0x00002233
- SB 0x101 wdata 0x000000AB, mem=0x11223344 -> READ at N+1, WRITE of 0x1122AB44 with done at N+3. SH 0x102 wdata 0xBEEF -> 0xBEEF3344.
- Starvation: both reqs held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F. With i_if_req only -> fetch rvalid every 3 cycles.
- Errors: SH 0x101, SW 0x102, size=11 -> gnt+err same cycle, o_mem_* stay 0, FSM remains IDLE.

Source files
------------

// File: rtl/cpu_mem_arb_pkg.sv
// rtl/cpu_mem_arb_pkg.sv - shared types and size encodings for the data memory arbiter
package cpu_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    RESP  = 2'd2,
    WRITE = 2'd3
  } mem_arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } mem_arb_owner_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/cpu_mem_lane_unit.sv
// rtl/cpu_mem_lane_unit.sv - load lane extraction/extension, store lane merge, alignment check
module cpu_mem_lane_unit
  import cpu_mem_arb_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (size)
      SIZE_B:  load_data = {{24{~zero_ext & byte_sel[7]}}, byte_sel};
      SIZE_H:  load_data = {{16{~zero_ext & half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Untouched lanes keep the word just read from memory.
  always_comb begin
    merge_data = rdata;
    case (size)
      SIZE_B: begin
        case (addr_lo)
          2'd0:    merge_data[7:0]   = wdata[7:0];
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          default: merge_data[31:24] = wdata[7:0];
        endcase
      end
      SIZE_H: begin
        if (addr_lo[1]) merge_data[31:16] = wdata[15:0];
        else            merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

  always_comb begin
    misaligned = (size == 2'b11)
               | ((size == SIZE_H) & addr_lo[0])
               | ((size == SIZE_W) & (addr_lo != 2'b00));
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - shares the single-port data memory between fetch and the memory unit
module cpu_mem_arbiter
  import cpu_mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [1:0]  i_dm_size,
  input  logic        i_dm_unsigned,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  output logic        o_dm_gnt,
  output logic        o_dm_rvalid,
  output logic [31:0] o_dm_rdata,
  output logic        o_dm_done,
  output logic        o_dm_err,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  mem_arb_state_t   state;
  mem_arb_owner_t   owner_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic [1:0]       size_q;
  logic             unsigned_q;
  logic [CNT_W-1:0] starve_cnt;

  logic        idle;
  logic        if_win;
  logic        dm_win;
  logic [1:0]  lane_addr;
  logic [1:0]  lane_size;
  logic [31:0] lane_load;
  logic [31:0] lane_merge;
  logic        lane_misaligned;

  // Grants are gated by reset so nothing is accepted while the block is held.
  always_comb begin
    idle   = (state == IDLE) & i_reset_n;
    if_win = idle & i_if_req & (~i_dm_req | (starve_cnt == LIMIT));
    dm_win = idle & i_dm_req & ~if_win;
  end

  // In IDLE the lane unit checks the live request; afterwards it serves the latched one.
  always_comb begin
    lane_addr = (state == IDLE) ? i_dm_addr[1:0] : addr_q[1:0];
    lane_size = (state == IDLE) ? i_dm_size : size_q;
  end

  cpu_mem_lane_unit u_lane (
    .addr_lo    (lane_addr),
    .size       (lane_size),
    .zero_ext   (unsigned_q),
    .rdata      (i_mem_rdata),
    .wdata      (wdata_q),
    .load_data  (lane_load),
    .merge_data (lane_merge),
    .misaligned (lane_misaligned)
  );

  always_comb begin
    o_if_gnt    = if_win;
    o_dm_gnt    = dm_win;
    o_dm_err    = dm_win & lane_misaligned;
    o_if_rvalid = (state == RESP) & (owner_q == OWN_IF);
    o_dm_rvalid = (state == RESP) & (owner_q == OWN_DM) & ~we_q;
    o_if_rdata  = o_if_rvalid ? i_mem_rdata : 32'h0;
    o_dm_rdata  = o_dm_rvalid ? lane_load : 32'h0;
    o_dm_done   = (state == WRITE);
    o_mem_addr  = 32'h0;
    o_mem_we    = 1'b0;
    o_mem_wdata = 32'h0;
    if (state == READ || state == WRITE) o_mem_addr = {addr_q[31:2], 2'b00};
    if (state == WRITE) begin
      o_mem_we    = 1'b1;
      o_mem_wdata = wdata_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      size_q     <= SIZE_W;
      unsigned_q <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (!i_if_req || if_win)             starve_cnt <= '0;
      else if (dm_win && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (if_win) begin
            owner_q    <= OWN_IF;
            addr_q     <= i_if_addr;
            we_q       <= 1'b0;
            size_q     <= SIZE_W;
            unsigned_q <= 1'b0;
            wdata_q    <= 32'h0;
            state      <= READ;
          end else if (dm_win && !lane_misaligned) begin
            owner_q    <= OWN_DM;
            addr_q     <= i_dm_addr;
            we_q       <= i_dm_we;
            size_q     <= i_dm_size;
            unsigned_q <= i_dm_unsigned;
            wdata_q    <= i_dm_wdata;
            state      <= (i_dm_we && i_dm_size == SIZE_W) ? WRITE : READ;
          end
        end
        READ: state <= RESP;
        RESP: begin
          if (owner_q == OWN_DM && we_q) begin
            wdata_q <= lane_merge;
            state   <= WRITE;
          end else begin
            state <= IDLE;
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - directed self-checking bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = 32'h0;
  logic        o_if_gnt, o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_dm_req = 1'b0;
  logic        i_dm_we = 1'b0;
  logic [1:0]  i_dm_size = 2'b10;
  logic        i_dm_unsigned = 1'b0;
  logic [31:0] i_dm_addr = 32'h0;
  logic [31:0] i_dm_wdata = 32'h0;
  logic        o_dm_gnt, o_dm_rvalid, o_dm_done, o_dm_err;
  logic [31:0] o_dm_rdata;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        o_mem_we;
  logic [31:0] i_mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = 8'h0;
  logic [31:0] bd_data = 32'h0;
  int          we_pulses = 0;
  logic [134:0] all_out;

  cpu_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_size(i_dm_size),
    .i_dm_unsigned(i_dm_unsigned), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
    .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
    .o_dm_done(o_dm_done), .o_dm_err(o_dm_err),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  assign all_out = {o_if_gnt, o_if_rvalid, o_if_rdata, o_dm_gnt, o_dm_rvalid, o_dm_rdata,
                    o_dm_done, o_dm_err, o_mem_addr, o_mem_we, o_mem_wdata};

  always @(posedge i_clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (o_mem_we) mem[o_mem_addr[9:2]] <= o_mem_wdata;
    i_mem_rdata <= mem[o_mem_addr[9:2]];
    if (o_mem_we) we_pulses <= we_pulses + 1;
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge i_clk);
    bd_we = 1'b1; bd_idx = a[9:2]; bd_data = d;
    @(negedge i_clk);
    bd_we = 1'b0;
  endtask

  task automatic drive_dm(input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd);
    i_dm_req = 1'b1; i_dm_we = we; i_dm_size = sz; i_dm_unsigned = u;
    i_dm_addr = a; i_dm_wdata = wd;
  endtask

  task automatic do_load(input string name, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] exp);
    @(negedge i_clk);
    drive_dm(1'b0, sz, u, a, 32'h0);
    #1;
    checks++;
    if ({o_dm_gnt, o_dm_err} !== 2'b10) begin
      errors++; $display("FAIL %s gnt/err: got %b required 10", name, {o_dm_gnt, o_dm_err});
    end
    @(negedge i_clk);
    i_dm_req = 1'b0;
    #1;
    checks++;
    if ({o_mem_we, o_mem_addr} !== {1'b0, a[31:2], 2'b00}) begin
      errors++; $display("FAIL %s read addr: got we=%b addr=%h required we=0 addr=%h",
                         name, o_mem_we, o_mem_addr, {a[31:2], 2'b00});
    end
    @(negedge i_clk);
    #1;
    checks++;
    if ({o_dm_rvalid, o_dm_rdata} !== {1'b1, exp}) begin
      errors++; $display("FAIL %s rdata: got rvalid=%b data=%h required rvalid=1 data=%h",
                         name, o_dm_rvalid, o_dm_rdata, exp);
    end
  endtask

  task automatic do_substore(input string name, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] wd, input logic [31:0] exp);
    @(negedge i_clk);
    drive_dm(1'b1, sz, 1'b0, a, wd);
    #1;
    checks++;
    if ({o_dm_gnt, o_dm_err} !== 2'b10) begin
      errors++; $display("FAIL %s gnt/err: got %b required 10", name, {o_dm_gnt, o_dm_err});
    end
    @(negedge i_clk);
    i_dm_req = 1'b0;
    #1;
    checks++;
    if ({o_mem_we, o_mem_addr, o_dm_done} !== {1'b0, a[31:2], 2'b00, 1'b0}) begin
      errors++; $display("FAIL %s read phase: got we=%b addr=%h done=%b required we=0 addr=%h done=0",
                         name, o_mem_we, o_mem_addr, o_dm_done, {a[31:2], 2'b00});
    end
    @(negedge i_clk);
    #1;
    checks++;
    if ({o_mem_we, o_dm_done} !== 2'b00) begin
      errors++; $display("FAIL %s resp phase: got we=%b done=%b required 0 0", name, o_mem_we, o_dm_done);
    end
    @(negedge i_clk);
    #1;
    checks++;
    if ({o_mem_we, o_dm_done, o_mem_addr, o_mem_wdata} !== {2'b11, a[31:2], 2'b00, exp}) begin
      errors++; $display("FAIL %s write: got we=%b done=%b addr=%h wdata=%h required 1 1 %h %h",
                         name, o_mem_we, o_dm_done, o_mem_addr, o_mem_wdata, {a[31:2], 2'b00}, exp);
    end
    @(negedge i_clk);
    #1;
    checks++;
    if (mem[a[9:2]] !== exp) begin
      errors++; $display("FAIL %s memory: got %h required %h", name, mem[a[9:2]], exp);
    end
  endtask

  task automatic test_reset();
    drive_dm(1'b1, 2'b10, 1'b0, 32'h100, 32'h1);
    i_if_req = 1'b1;
    @(negedge i_clk);
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset outputs: got %h required 0", all_out);
    end
    i_dm_req = 1'b0; i_if_req = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL idle outputs after reset: got %h required 0", all_out);
    end
  endtask

  task automatic test_word_access();
    preload(32'h100, 32'hDEADBEEF);
    do_load("lw_0x100", 32'h100, 2'b10, 1'b0, 32'hDEADBEEF);
    @(negedge i_clk);
    drive_dm(1'b1, 2'b10, 1'b0, 32'h104, 32'hA5A5_0F0F);
    #1;
    checks++;
    if ({o_dm_gnt, o_dm_err, o_mem_we} !== 3'b100) begin
      errors++; $display("FAIL sw gnt: got %b required 100", {o_dm_gnt, o_dm_err, o_mem_we});
    end
    @(negedge i_clk);
    i_dm_req = 1'b0;
    #1;
    checks++;
    if ({o_mem_we, o_dm_done, o_mem_addr, o_mem_wdata} !== {2'b11, 32'h104, 32'hA5A5_0F0F}) begin
      errors++; $display("FAIL sw write: got we=%b done=%b addr=%h wdata=%h required 1 1 00000104 a5a50f0f",
                         o_mem_we, o_dm_done, o_mem_addr, o_mem_wdata);
    end
  endtask

  task automatic test_subword_loads();
    preload(32'h100, 32'h80112233);
    do_load("lb_0x103",  32'h103, 2'b00, 1'b0, 32'hFFFFFF80);
    do_load("lbu_0x103", 32'h103, 2'b00, 1'b1, 32'h00000080);
    do_load("lh_0x102",  32'h102, 2'b01, 1'b0, 32'hFFFF8011);
    do_load("lhu_0x100", 32'h100, 2'b01, 1'b1, 32'h00002233);
  endtask

  task automatic test_substores();
    preload(32'h100, 32'h11223344);
    do_substore("sb_0x101", 32'h101, 2'b00, 32'h000000AB, 32'h1122AB44);
    preload(32'h100, 32'h11223344);
    do_substore("sh_0x102", 32'h102, 2'b01, 32'h0000BEEF, 32'hBEEF3344);
  endtask

  task automatic test_errors();
    logic [1:0]  sz [3];
    logic [31:0] ad [3];
    logic        we [3];
    sz[0] = 2'b01; ad[0] = 32'h101; we[0] = 1'b1;
    sz[1] = 2'b10; ad[1] = 32'h102; we[1] = 1'b1;
    sz[2] = 2'b11; ad[2] = 32'h100; we[2] = 1'b0;
    // Back-to-back error grants only work if the FSM never leaves IDLE.
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      drive_dm(we[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF);
      #1;
      checks++;
      if ({o_dm_gnt, o_dm_err, o_mem_we, o_mem_addr, o_mem_wdata} !== {3'b110, 64'h0}) begin
        errors++; $display("FAIL err_%0d: got gnt=%b err=%b we=%b addr=%h wdata=%h required 1 1 0 0 0",
                           i, o_dm_gnt, o_dm_err, o_mem_we, o_mem_addr, o_mem_wdata);
      end
    end
    @(negedge i_clk);
    i_dm_req = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL err_quiet: got %h required 0", all_out);
    end
  endtask

  task automatic test_fetch_only();
    int gnt_cyc [$];
    int rv_cnt = 0;
    int cyc = 0;
    preload(32'h200, 32'hCAFEF00D);
    @(negedge i_clk);
    i_if_req = 1'b1; i_if_addr = 32'h202;
    while (rv_cnt < 4 && cyc < 40) begin
      #1;
      if (o_if_gnt) gnt_cyc.push_back(cyc);
      if (o_if_rvalid) begin
        checks++;
        if (gnt_cyc.size() == 0 || o_if_rdata !== 32'hCAFEF00D || cyc != gnt_cyc[$] + 2) begin
          errors++; $display("FAIL fetch_rvalid: got data=%h at cycle %0d required cafef00d two cycles after grant",
                             o_if_rdata, cyc);
        end
        rv_cnt++;
      end
      @(negedge i_clk);
      cyc++;
    end
    i_if_req = 1'b0;
    checks++;
    if (rv_cnt != 4) begin
      errors++; $display("FAIL fetch_count: got %0d responses required 4", rv_cnt);
    end
    for (int i = 1; i < gnt_cyc.size(); i++) begin
      checks++;
      if (gnt_cyc[i] - gnt_cyc[i-1] != 3) begin
        errors++; $display("FAIL fetch_spacing: got %0d cycles required 3", gnt_cyc[i] - gnt_cyc[i-1]);
      end
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_starvation();
    logic [9:0] seq = '0;
    int n = 0;
    int cyc = 0;
    @(negedge i_clk);
    i_if_req = 1'b1; i_if_addr = 32'h200;
    drive_dm(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    while (n < 10 && cyc < 80) begin
      #1;
      if (o_if_gnt && o_dm_gnt) begin
        checks++; errors++;
        $display("FAIL starve_double_grant: got both grants at cycle %0d required one", cyc);
      end
      if (o_if_gnt || o_dm_gnt) begin
        seq[n] = o_if_gnt;
        n++;
      end
      @(negedge i_clk);
      cyc++;
    end
    i_if_req = 1'b0; i_dm_req = 1'b0;
    checks++;
    if (n != 10 || seq !== 10'b10_0001_0000) begin
      errors++; $display("FAIL starve_order: got %0d grants pattern %b required 10 grants pattern 1000010000 (bit0 first, 1=fetch)",
                         n, seq);
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_reset_midop();
    int w0;
    preload(32'h100, 32'h11223344);
    w0 = we_pulses;
    @(negedge i_clk);
    drive_dm(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AB);
    #1;
    checks++;
    if (o_dm_gnt !== 1'b1) begin
      errors++; $display("FAIL midop_gnt: got %b required 1", o_dm_gnt);
    end
    @(negedge i_clk);
    i_dm_req = 1'b0;
    @(negedge i_clk);
    #1;
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL midop_reset_outputs: got %h required 0", all_out);
    end
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk);
    #1;
    checks++;
    if (we_pulses != w0 || mem[8'h40] !== 32'h11223344) begin
      errors++; $display("FAIL midop_no_write: got pulses=%0d mem=%h required pulses=%0d mem=11223344",
                         we_pulses, mem[8'h40], w0);
    end
    do_load("lw_after_reset", 32'h100, 2'b10, 1'b0, 32'h11223344);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word_access();
    test_subword_loads();
    test_substores();
    test_errors();
    test_fetch_only();
    test_starvation();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
